// File: rtl/lcd_rx_if.sv
// ---------------------------------------------------------------------------
// lcd_rx_if -- HD44780-style parallel write bus between an LCD writer and
// the lcd_rx controller model.
//
// Signals:
//   lcd_e     enable strobe; a transfer is taken on its falling edge
//   lcd_rs    0 = instruction, 1 = data
//   lcd_rw    0 = write, 1 = read cycle (ignored by the receiver)
//   lcd_on    panel power; strobes are ignored while 0
//   data_lcd  8-bit data bus
//
// Modports:
//   master  the writer, drives every signal
//   slave   the receiver, samples every signal
// ---------------------------------------------------------------------------
interface lcd_rx_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_on;
  logic [7:0] data_lcd;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_on, data_lcd);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_on, data_lcd);
endinterface

// File: rtl/lcd_rx.sv
// ---------------------------------------------------------------------------
// lcd_rx -- receive side of a 2x16 character LCD controller. Decodes the
// instruction/data stream written on the LCD bus, keeps the DDRAM address
// counter and a 32-cell shadow of the visible characters, and models the
// controller busy time.
//
// Parameters:
//   BUSY_CYCLES  busy length after any accepted non-clear transfer (>= 1)
//   CLR_CYCLES   busy length after clear-display (>= 32)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bus         lcd_rx_if.slave: lcd_e, lcd_rs, lcd_rw, lcd_on, data_lcd
//   rd_addr     cell select, 0-15 line 1, 16-31 line 2
//   rd_char     character in the selected cell (combinational)
//   disp_on     display-on bit from display control
//   two_line    N bit from function set
//   addr_cnt    DDRAM address counter (AC)
//   busy        controller busy
//   addr_err    sticky: set-DDRAM to a non-existent address
//   overrun     sticky: transfer arrived while busy
//   frame_done  one-cycle pulse when a data write lands in cell 31
//   frame_cnt   count of completed frames
//
// Build option: define LCD_RX_FRAME_EN to enable frame_done/frame_cnt;
// without it both outputs are constant 0.
// ---------------------------------------------------------------------------
module lcd_rx #(
  parameter int BUSY_CYCLES = 2000,
  parameter int CLR_CYCLES  = 82000
) (
  input  logic        clk,
  input  logic        rst,
  lcd_rx_if.slave     bus,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_char,
  output logic        disp_on,
  output logic        two_line,
  output logic [6:0]  addr_cnt,
  output logic        busy,
  output logic        addr_err,
  output logic        overrun,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int MAX_CYCLES = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // ST_CLEAR: busy while sweeping 0x20 into the cells; ST_HOLD: plain busy.
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_HOLD} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0]    clr_idx;

  logic          e_q, rs_q, rw_q, on_q;
  logic [7:0]    data_q;

  logic          inc_dec;
  logic          cgram_mode;
  logic [7:0]    cells [32];

  // AC step with the two-line wrap: 0x27<->0x40 and 0x67<->0x00.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == 7'h27)      return 7'h40;
      else if (ac == 7'h67) return 7'h00;
      else                  return ac + 7'd1;
    end else begin
      if (ac == 7'h00)      return 7'h67;
      else if (ac == 7'h40) return 7'h27;
      else                  return ac - 7'd1;
    end
  endfunction

  function automatic logic ddram_ok(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  // Bus input register; the transfer is taken from these values on the
  // cycle the live strobe is seen low after being high.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      on_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      e_q    <= bus.lcd_e;
      rs_q   <= bus.lcd_rs;
      rw_q   <= bus.lcd_rw;
      on_q   <= bus.lcd_on;
      data_q <= bus.data_lcd;
    end
  end

  logic strobe, valid, accept, is_clear;
  logic cell_hit, write_cell;
  logic [4:0] cell_sel;

  assign strobe   = e_q & ~bus.lcd_e;
  assign valid    = strobe & ~rw_q & on_q;
  assign accept   = valid & (state == ST_IDLE);
  assign is_clear = ~rs_q & (data_q == 8'h01);
  assign busy     = (state != ST_IDLE);

  // Only AC 0x00-0x0F and 0x40-0x4F map onto visible cells.
  assign cell_hit   = (addr_cnt[6:4] == 3'b000) || (addr_cnt[6:4] == 3'b100);
  assign cell_sel   = {addr_cnt[6], addr_cnt[3:0]};
  assign write_cell = accept & rs_q & ~cgram_mode & cell_hit;

  // Busy FSM ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clr_idx <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      if (state == ST_CLEAR) clr_idx <= clr_idx + 5'd1;
      else                   clr_idx <= '0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned and infers a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_clear ? ST_CLEAR : ST_HOLD;
          cnt_d   = is_clear ? CW'(CLR_CYCLES) : CW'(BUSY_CYCLES);
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1))          state_d = ST_IDLE;
        else if (clr_idx == 5'd31)  state_d = ST_HOLD;
      end
      ST_HOLD: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Instruction / data decode -------------------------------------------------
  // Cursor and blink bits have no observable effect in this model, so only
  // the display-on bit of display control is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt   <= 7'h00;
      inc_dec    <= 1'b1;
      disp_on    <= 1'b0;
      two_line   <= 1'b0;
      cgram_mode <= 1'b0;
      addr_err   <= 1'b0;
      overrun    <= 1'b0;
    end else if (valid && busy) begin
      overrun <= 1'b1;
    end else if (accept) begin
      if (rs_q) begin
        if (!cgram_mode) addr_cnt <= ac_step(addr_cnt, inc_dec);
      end else begin
        casez (data_q)
          8'b1???????: begin
            if (ddram_ok(data_q[6:0])) addr_cnt <= data_q[6:0];
            else                       addr_err <= 1'b1;
            cgram_mode <= 1'b0;
          end
          8'b01??????: cgram_mode <= 1'b1;
          8'b001?????: two_line   <= data_q[3];
          8'b0001????: if (!data_q[3]) addr_cnt <= ac_step(addr_cnt, data_q[2]);
          8'b00001???: disp_on    <= data_q[2];
          8'b000001??: inc_dec    <= data_q[1];
          8'b0000001?: addr_cnt   <= 7'h00;
          8'b00000001: begin
            addr_cnt   <= 7'h00;
            inc_dec    <= 1'b1;
            cgram_mode <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Character cells -----------------------------------------------------------
  // NOTE: the cells are a reset register array rather than a RAM because
  // reset must return every cell to a blank (0x20) immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
    end else if (state == ST_CLEAR) begin
      cells[clr_idx] <= 8'h20;
    end else if (write_cell) begin
      cells[cell_sel] <= data_q;
    end
  end

  assign rd_char = cells[rd_addr];

  // Frame counter -------------------------------------------------------------
`ifdef LCD_RX_FRAME_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      frame_done <= write_cell && (cell_sel == 5'd31);
      if (write_cell && (cell_sel == 5'd31)) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_done = 1'b0;
  assign frame_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd_rx -- directed plus randomized bench for lcd_rx. A behavioural model
// treats the DDRAM address space as an 80-position ring and the display as a
// 32-byte array; every transfer updates the model and the bench compares
// busy length, status outputs and all 32 cells against it.
// ---------------------------------------------------------------------------
module tb_lcd_rx;

  localparam int BUSY = 20;
  localparam int CLR  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_char;
  logic        disp_on, two_line, busy, addr_err, overrun, frame_done;
  logic [6:0]  addr_cnt;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  lcd_rx_if bus();

  lcd_rx #(.BUSY_CYCLES(BUSY), .CLR_CYCLES(CLR)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rd_addr    (rd_addr),
    .rd_char    (rd_char),
    .disp_on    (disp_on),
    .two_line   (two_line),
    .addr_cnt   (addr_cnt),
    .busy       (busy),
    .addr_err   (addr_err),
    .overrun    (overrun),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  m_cells [32];
  int          m_pos;           // AC as ring position 0..79
  logic        m_inc, m_disp, m_two, m_cg, m_aerr, m_ovr;
  logic [15:0] m_fcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pos_to_ac(input int p);
    return (p < 40) ? 7'(p) : 7'(p - 40 + 'h40);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_pos = 0; m_inc = 1'b1; m_disp = 1'b0; m_two = 1'b0;
    m_cg = 1'b0; m_aerr = 1'b0; m_ovr = 1'b0; m_fcnt = 16'h0;
  endtask

  // Apply one accepted transfer; returns expected busy length and whether
  // cell 31 was written.
  task automatic model_apply(input logic rs, input logic [7:0] d,
                             output int blen, output logic fev);
    int a;
    blen = BUSY;
    fev  = 1'b0;
    if (rs) begin
      if (!m_cg) begin
        if (m_pos < 16) m_cells[m_pos] = d;
        else if (m_pos >= 40 && m_pos < 56) begin
          m_cells[m_pos - 24] = d;
          if (m_pos == 55) fev = 1'b1;
        end
        m_pos = (m_pos + (m_inc ? 1 : 79)) % 80;
      end
    end else if (d >= 8'h80) begin
      a = int'(d) - 128;
      if (a <= 'h27)                    m_pos = a;
      else if (a >= 'h40 && a <= 'h67)  m_pos = a - 'h40 + 40;
      else                              m_aerr = 1'b1;
      m_cg = 1'b0;
    end else if (d >= 8'h40) m_cg = 1'b1;
    else if (d >= 8'h20) m_two = d[3];
    else if (d >= 8'h10) begin
      if (!d[3]) m_pos = (m_pos + (d[2] ? 1 : 79)) % 80;
    end
    else if (d >= 8'h08) m_disp = d[2];
    else if (d >= 8'h04) m_inc = d[1];
    else if (d >= 8'h02) m_pos = 0;
    else if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
      m_pos = 0; m_inc = 1'b1; m_cg = 1'b0;
      blen = CLR;
    end
`ifdef LCD_RX_FRAME_EN
    if (fev) m_fcnt = m_fcnt + 16'd1;
`else
    fev = 1'b0;
`endif
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"},       addr_cnt,  pos_to_ac(m_pos));
    check({tag, "_disp_on"},  disp_on,   m_disp);
    check({tag, "_two_line"}, two_line,  m_two);
    check({tag, "_addr_err"}, addr_err,  m_aerr);
    check({tag, "_overrun"},  overrun,   m_ovr);
    check({tag, "_busy"},     busy,      1'b0);
    check({tag, "_frame_cnt"}, frame_cnt, m_fcnt);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      check($sformatf("%s_cell%0d", tag, i), rd_char, m_cells[i]);
    end
  endtask

  // One strobe; returns one time unit after the capture edge.
  task automatic strobe(input logic rs, input logic [7:0] d, input logic rw, input logic on);
    @(negedge clk);
    bus.lcd_e = 1'b1; bus.lcd_rs = rs; bus.data_lcd = d; bus.lcd_rw = rw; bus.lcd_on = on;
    @(negedge clk);
    bus.lcd_e = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Count busy-high samples from the current one; bounded.
  task automatic busy_len(input string tag, input int exp_len);
    int n = 0;
    int guard = 0;
    while (busy === 1'b1 && guard < CLR + 50) begin
      n++;
      guard++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_len"}, n, exp_len);
  endtask

  task automatic xfer(input string tag, input logic rs, input logic [7:0] d);
    int   blen;
    logic fev;
    strobe(rs, d, 1'b0, 1'b1);
    model_apply(rs, d, blen, fev);
    check({tag, "_frame_done"}, frame_done, fev);
    busy_len(tag, blen);
    check_state(tag);
  endtask

  task automatic ignored(input string tag, input logic rs, input logic [7:0] d,
                         input logic rw, input logic on);
    strobe(rs, d, rw, on);
    check({tag, "_busy_now"}, busy, 1'b0);
    @(negedge clk);
    bus.lcd_on = 1'b1;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int   r;
    logic [7:0] d;
    rst = 1'b1;
    rd_addr = '0;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0;
    bus.lcd_on = 1'b1; bus.data_lcd = 8'h00;
    repeat (3) @(posedge clk);
    do_reset();
    #1;
    check("rst_inc_dec_via_frame_done", frame_done, 1'b0);
    check_state("reset");

    // Power-up init sequence
    xfer("init38", 1'b0, 8'h38);
    xfer("init0c", 1'b0, 8'h0C);
    xfer("init06", 1'b0, 8'h06);
    xfer("init01", 1'b0, 8'h01);
    xfer("init80", 1'b0, 8'h80);
    check("init_two_line", two_line, 1'b1);
    check("init_disp_on",  disp_on,  1'b1);

    // Two data bytes on line 1
    xfer("d41", 1'b1, 8'h41);
    xfer("d3d", 1'b1, 8'h3D);
    check("line1_ac", addr_cnt, 7'h02);

    // Fill line 2; last write completes a frame
    xfer("sel_line2", 1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) xfer($sformatf("l2_%0d", i), 1'b1, 8'(8'h30 + i));
    check("line2_ac", addr_cnt, 7'h50);

    // Non-existent address, then wrap from 0x27 to 0x40
    xfer("bad_addr", 1'b0, 8'hA8);
    check("bad_addr_flag", addr_err, 1'b1);
    xfer("set27", 1'b0, 8'hA7);
    xfer("wrap_w1", 1'b1, 8'h5A);
    check("wrap_ac", addr_cnt, 7'h40);
    xfer("wrap_w2", 1'b1, 8'h5B);

    // Decrement wrap 0x00 -> 0x67 and CGRAM discard
    xfer("entry_dec", 1'b0, 8'h04);
    xfer("set00", 1'b0, 8'h80);
    xfer("dec_w", 1'b1, 8'h61);
    check("dec_wrap_ac", addr_cnt, 7'h67);
    xfer("cgram", 1'b0, 8'h40);
    xfer("cgram_w", 1'b1, 8'h99);
    xfer("entry_inc", 1'b0, 8'h06);

    // Overrun: second strobe lands 10 cycles into the first's busy time
    begin
      int   blen;
      logic fev;
      strobe(1'b0, 8'h83, 1'b0, 1'b1);
      model_apply(1'b0, 8'h83, blen, fev);
      repeat (8) @(posedge clk);
      strobe(1'b1, 8'h77, 1'b0, 1'b1);
      m_ovr = 1'b1;
      check("ovr_busy_still", busy, 1'b1);
      busy_len("ovr_tail", BUSY - 10);
      check_state("overrun");
    end

    // Read cycle and powered-off strobe are ignored
    ignored("rw_read", 1'b1, 8'h55, 1'b1, 1'b1);
    ignored("power_off", 1'b1, 8'h66, 1'b0, 1'b0);

    // Reset in the middle of a clear sweep
    xfer("pre_clr", 1'b1, 8'h4B);
    strobe(1'b0, 8'h01, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    do_reset();
    #1;
    check_state("rst_mid_clear");

    // Randomized traffic
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 19));
      d = 8'($urandom);
      if (r < 8)        xfer($sformatf("rnd%0d_data", k), 1'b1, d);
      else if (r < 11)  xfer($sformatf("rnd%0d_ddram", k), 1'b0, d | 8'h80);
      else if (r < 12)  xfer($sformatf("rnd%0d_clear", k), 1'b0, 8'h01);
      else if (r < 18)  xfer($sformatf("rnd%0d_instr", k), 1'b0, 8'($urandom_range(2, 127)));
      else if (r == 18) ignored($sformatf("rnd%0d_rw", k), d[0], d, 1'b1, 1'b1);
      else              ignored($sformatf("rnd%0d_off", k), d[0], d, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
